// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (IF) and load/store (DM), one access in flight.
// Optional IF anti-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            if_flush,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [DW/8-1:0] dm_be,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic            dm_gnt,
    output logic            dm_rvalid,
    output logic [DW-1:0]   dm_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic            if_stall,
    output logic            dm_stall
);

    localparam int CW = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_IF,
        WAIT_DM
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            drop;
    logic            done;
    logic            can_issue;
    logic            force_if;
    logic            if_win;

    assign done      = (state != IDLE) && (cnt == CW'(MEM_LATENCY));
    assign can_issue = (state == IDLE) || done;

    assign if_win = if_req && (!dm_req || force_if);
    assign if_gnt = can_issue && if_win;
    assign dm_gnt = can_issue && dm_req && !if_win;

    // A flush in the completion cycle itself also kills the returning fetch.
    assign if_rvalid = done && (state == WAIT_IF) && !drop && !if_flush;
    assign dm_rvalid = done && (state == WAIT_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

    assign if_stall = if_req && !if_rvalid;
    assign dm_stall = dm_req && !dm_rvalid;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_be    = dm_be;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_be   = '1;
            mem_addr = if_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            drop  <= 1'b0;
        end else if (if_gnt) begin
            state <= WAIT_IF;
            cnt   <= CW'(1);
            drop  <= if_flush;
        end else if (dm_gnt) begin
            state <= WAIT_DM;
            cnt   <= CW'(1);
            drop  <= 1'b0;
        end else if (done) begin
            state <= IDLE;
            cnt   <= '0;
            drop  <= 1'b0;
        end else if (state != IDLE) begin
            cnt <= cnt + CW'(1);
            if (state == WAIT_IF && if_flush) begin
                drop <= 1'b1;
            end
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt;

    assign force_if = (starve_cnt >= 3'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (dm_gnt && if_req && starve_cnt != 3'd7) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    assign force_if = 1'b0 && (STARVE_LIMIT > 0);
`endif

endmodule
